nabp_tap_line_buffer: RTL and testbench

Parametrised PE tap delay line for the processing swappable path. It replaces the fixed two-implementation line buffer (vendor shift-taps versus debug shift-register chain) with a single portable ring-buffer design. It produces `NUM_TAPS` filtered-data taps spaced `TAP_DIST` enabled shifts apart, and adds per-tap fill tracking with an O(1) clear. It sits between the filtered RAM output and the PE array, and is clocked by the mapper shift enable.

---
 rtl/nabp_pkg.sv | 12 +
 rtl/nabp_tap_segment.sv | 26 ++
 rtl/nabp_tap_line_buffer.sv | 85 ++++++++
 tb/tb_nabp_tap_line_buffer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/nabp_pkg.sv
// nabp_pkg: shared constants and helpers for the NABP processing path
package nabp_pkg;
    localparam int FILT_W    = 16;
    localparam int NUM_PART  = 4;
    localparam int PART_SIZE = 8;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/nabp_tap_segment.sv
// nabp_tap_segment: one tap stage, a ring memory feeding an output register
module nabp_tap_segment
    import nabp_pkg::*;
#(
    parameter int DATA_W = FILT_W,
    parameter int DEPTH  = PART_SIZE - 1,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  ptr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];
    // Ring storage: contents carry no meaning after reset, so it is left unreset
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= din;
    end
    // Output register takes the oldest entry just before it is overwritten
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dout <= '0;
        else if (wr_en) dout <= mem[ptr];
    end
endmodule

// File: rtl/nabp_tap_line_buffer.sv
// nabp_tap_line_buffer: PE tap delay line with fill tracking (NABP_TAP_ZERO_FILL_EN masks invalid taps to zero)
module nabp_tap_line_buffer
    import nabp_pkg::*;
#(
    parameter int DATA_W   = FILT_W,
    parameter int NUM_TAPS = NUM_PART,
    parameter int TAP_DIST = PART_SIZE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          val_in,
    input  logic                       shift_en,
    input  logic                       clear,
    output logic [DATA_W*NUM_TAPS-1:0] taps,
    output logic [NUM_TAPS-1:0]        tap_valid,
    output logic                       fill_done
);
    localparam int FILL_MAX = (NUM_TAPS - 1) * TAP_DIST;
    localparam int CNT_W    = clog2(FILL_MAX + 1);
    localparam int PTR_W    = TAP_DIST > 2 ? clog2(TAP_DIST - 1) : 1;
    logic [DATA_W-1:0] tap0;
    logic [DATA_W-1:0] seg_q [NUM_TAPS-1:1];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  fill_cnt;
    logic              adv;
    assign adv = shift_en & ~clear;
    // Tap 0 follows the RAM output every clock, independent of shift_en
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tap0 <= '0;
        else tap0 <= val_in;
    end
    // Shared ring pointer, saturating fill counter and one-shot completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
        end else if (clear) begin
            ptr       <= '0;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= shift_en && fill_cnt == CNT_W'(FILL_MAX - 1);
            if (shift_en) begin
                ptr <= ptr == PTR_W'(TAP_DIST - 2) ? '0 : ptr + 1'b1;
                if (fill_cnt != CNT_W'(FILL_MAX)) fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end
    for (genvar k = 1; k < NUM_TAPS; k++) begin : g_seg
        logic [DATA_W-1:0] din;
        if (k == 1) begin : g_first
            assign din = tap0;
        end else begin : g_next
            assign din = seg_q[k-1];
        end
        nabp_tap_segment #(
            .DATA_W(DATA_W),
            .DEPTH (TAP_DIST - 1),
            .PTR_W (PTR_W)
        ) u_seg (
            .clk    (clk),
            .reset_n(reset_n),
            .wr_en  (adv),
            .ptr    (ptr),
            .din    (din),
            .dout   (seg_q[k])
        );
    end
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_out
        logic [DATA_W-1:0] raw;
        if (k == 0) begin : g_t0
            assign raw          = tap0;
            assign tap_valid[0] = 1'b1;
        end else begin : g_tk
            assign raw          = seg_q[k];
            assign tap_valid[k] = fill_cnt >= CNT_W'(k * TAP_DIST);
        end
`ifdef NABP_TAP_ZERO_FILL_EN
        assign taps[k*DATA_W +: DATA_W] = tap_valid[k] ? raw : '0;
`else
        assign taps[k*DATA_W +: DATA_W] = raw;
`endif
    end
endmodule

// File: tb/tb_nabp_tap_line_buffer.sv
// tb_nabp_tap_line_buffer: directed self-checking bench for nabp_tap_line_buffer
module tb_nabp_tap_line_buffer;
    localparam int W = 16;
    localparam int N = 4;
    localparam int D = 8;
`ifdef NABP_TAP_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif
    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [W-1:0]   val_in = '0;
    logic           shift_en = 1'b0;
    logic           clear = 1'b0;
    logic [W*N-1:0] taps;
    logic [N-1:0]   tap_valid;
    logic           fill_done;
    int n_checks = 0;
    int n_fail = 0;
    int pulses;

    always #5 clk = ~clk;

    nabp_tap_line_buffer #(.DATA_W(W), .NUM_TAPS(N), .TAP_DIST(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .val_in   (val_in),
        .shift_en (shift_en),
        .clear    (clear),
        .taps     (taps),
        .tap_valid(tap_valid),
        .fill_done(fill_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] tap(input int k);
        return taps[k*W +: W];
    endfunction

    task automatic tick(input logic [W-1:0] v, input logic s, input logic c);
        val_in   = v;
        shift_en = s;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_taps", taps, 0);
        check("rst_valid", tap_valid, 4'b0001);
        check("rst_done", fill_done, 0);
        reset_n = 1'b1;
        tick(0, 0, 0);
        check("idle_taps", taps, 0);

        pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            tick(W'(n), 1, 0);
            pulses += int'(fill_done);
            if (n == 8) check("fill_valid8", tap_valid, 4'b0011);
            if (n == 23) check("fill_valid23", tap_valid, 4'b0111);
            if (n == 23) check("fill_done23", fill_done, 0);
            if (n == 24) check("fill_valid24", tap_valid, 4'b1111);
            if (n == 24) check("fill_done24", fill_done, 1);
        end
        check("fill_pulses", pulses, 1);
        check("fill_t0", tap(0), 30);
        check("fill_t1", tap(1), 22);
        check("fill_t2", tap(2), 14);
        check("fill_t3", tap(3), 6);

        for (int i = 0; i < 5; i++) begin
            tick(i == 4 ? W'(30) : W'(77), 0, 0);
            if (i == 0) check("gap_t0_ungated", tap(0), 77);
        end
        check("gap_t1", tap(1), 22);
        check("gap_t2", tap(2), 14);
        check("gap_t3", tap(3), 6);
        check("gap_valid", tap_valid, 4'b1111);
        for (int n = 31; n <= 40; n++) tick(W'(n), 1, 0);
        check("resume_t0", tap(0), 40);
        check("resume_t1", tap(1), 32);
        check("resume_t2", tap(2), 24);
        check("resume_t3", tap(3), 16);

        tick(41, 0, 1);
        check("clr_valid", tap_valid, 4'b0001);
        check("clr_done", fill_done, 0);
        check("clr_t0", tap(0), 41);
        check("clr_t1", tap(1), ZF ? 0 : 32);
        check("clr_t3", tap(3), ZF ? 0 : 16);
        pulses = 0;
        for (int m = 1; m <= 30; m++) begin
            tick(W'(1000 + m), 1, 0);
            pulses += int'(fill_done);
            if (m == 7) check("clr_valid7", tap_valid, 4'b0001);
            if (m == 7) check("clr_t1_m7", tap(1), ZF ? 0 : 34);
            if (m == 8) check("clr_valid8", tap_valid, 4'b0011);
            if (m == 8) check("clr_t1_m8", tap(1), 41);
            if (m == 24) check("clr_done24", fill_done, 1);
            if (m == 24) check("clr_t3_m24", tap(3), 41);
            if (m == 24) check("clr_t2_m24", tap(2), 1008);
            if (m == 24) check("clr_t1_m24", tap(1), 1016);
        end
        check("clr_pulses", pulses, 1);

        tick(2000, 1, 1);
        check("cs_valid", tap_valid, 4'b0001);
        check("cs_done", fill_done, 0);
        check("cs_t1", tap(1), ZF ? 0 : 1022);
        check("cs_t3", tap(3), ZF ? 0 : 1006);
        pulses = 0;
        for (int j = 1; j <= 124; j++) begin
            tick(W'(2000 + j), 1, 0);
            pulses += int'(fill_done);
            if (j == 7) check("cs_valid7", tap_valid, 4'b0001);
            if (j == 8) check("cs_valid8", tap_valid, 4'b0011);
            if (j == 8) check("cs_t1_j8", tap(1), 2000);
            if (j == 24) check("cs_done24", fill_done, 1);
            if (j > 24 && tap_valid != 4'b1111) check("sat_valid_hold", tap_valid, 4'b1111);
        end
        check("sat_pulses", pulses, 1);
        check("sat_valid", tap_valid, 4'b1111);
        check("sat_t0", tap(0), 2124);
        check("sat_t1", tap(1), 2116);
        check("sat_t2", tap(2), 2108);
        check("sat_t3", tap(3), 2100);

        #3 reset_n = 1'b0;
        #1;
        check("arst_taps", taps, 0);
        check("arst_valid", tap_valid, 4'b0001);
        check("arst_done", fill_done, 0);
        reset_n = 1'b1;
        tick(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
